store_bram_w_b_i: RTL

STORE_BRAM_W_B_I -- requirements
Module: store_bram_w_b_i

---
 rtl/store_bram_w_b_i.sv | 122 ++++++++++++
 1 files changed

// File: rtl/store_bram_w_b_i.sv
// -----------------------------------------------------------------------------
// store_bram_w_b_i
// Streams one tile of result words into BRAM port B. A tile is 32 or 512 words
// and lands at base + offset, where base selects a buffer region
// (Buffer_Select * BUF_STRIDE). The offset runs on from tile to tile, so
// consecutive tiles pack contiguously. It wraps inside the region and is
// cleared only by reset_addr_counter while idle, or by rst_n.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start_store         one-cycle request to store a tile (honoured in IDLE)
//   reset_addr_counter  clear running offset (honoured in IDLE)
//   Buffer_Select[2:0]  target region, latched at start
//   Tiles_Control       1: 32-word tile, 0: 512-word tile, latched at start
//   in_valid/in_data    result word stream; in_ready marks acceptance
//   enb/web/addrb/dinb  BRAM port-B write, one cycle after acceptance
//   store_done          one-cycle pulse alongside the final write
//   busy                high while not IDLE
// -----------------------------------------------------------------------------
module store_bram_w_b_i #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 256,
   parameter int BUF_STRIDE = 2048
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_store,
   input  logic                  reset_addr_counter,
   input  logic [2:0]            Buffer_Select,
   input  logic                  Tiles_Control,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  enb,
   output logic                  web,
   output logic [ADDR_WIDTH-1:0] addrb,
   output logic [DATA_WIDTH-1:0] dinb,
   output logic                  store_done,
   output logic                  busy
);

   localparam int OFF_W = $clog2(BUF_STRIDE);

   typedef enum logic [1:0] {IDLE, STORE, DONE} state_t;

   state_t                  state_q;
   logic [OFF_W-1:0]        offset_q;   // wraps naturally at BUF_STRIDE
   logic [ADDR_WIDTH-1:0]   base_q;
   logic                    tiles_q;
   logic [8:0]              beat_q;
   logic                    in_ready_q, enb_q, web_q, store_done_q, busy_q;
   logic [ADDR_WIDTH-1:0]   addrb_q;
   logic [DATA_WIDTH-1:0]   dinb_q;

   logic last_beat;
   assign last_beat = tiles_q ? (beat_q == 9'd31) : (beat_q == 9'd511);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         offset_q     <= '0;
         base_q       <= '0;
         tiles_q      <= 1'b0;
         beat_q       <= '0;
         in_ready_q   <= 1'b0;
         enb_q        <= 1'b0;
         web_q        <= 1'b0;
         store_done_q <= 1'b0;
         busy_q       <= 1'b0;
         addrb_q      <= '0;
         dinb_q       <= '0;
      end else begin
         // Write strobes and done are pulses; addrb/dinb hold between writes.
         enb_q        <= 1'b0;
         web_q        <= 1'b0;
         store_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (reset_addr_counter) offset_q <= '0;
               if (start_store) begin
                  state_q    <= STORE;
                  base_q     <= ADDR_WIDTH'({Buffer_Select, {OFF_W{1'b0}}});
                  tiles_q    <= Tiles_Control;
                  beat_q     <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            STORE: begin
               // in_ready_q is high throughout STORE, so in_valid alone accepts.
               if (in_valid) begin
                  enb_q    <= 1'b1;
                  web_q    <= 1'b1;
                  dinb_q   <= in_data;
                  addrb_q  <= base_q + ADDR_WIDTH'(offset_q);
                  offset_q <= offset_q + OFF_W'(1);
                  beat_q   <= beat_q + 9'd1;
                  if (last_beat) begin
                     state_q      <= DONE;
                     in_ready_q   <= 1'b0;
                     store_done_q <= 1'b1;  // coincides with the final write
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign enb        = enb_q;
   assign web        = web_q;
   assign addrb      = addrb_q;
   assign dinb       = dinb_q;
   assign store_done = store_done_q;
   assign busy       = busy_q;

endmodule
